// File: rtl/gate_tester_pkg.sv
// Shared definitions for the two-input gate tester: FSM states and the
// reference truth tables a tester instance can be parameterised with.
package gate_tester_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   // Truth tables are indexed by the vector {in1,in2}
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_NAND = 4'b0111;

   localparam int unsigned SETTLE_MAX = 15;

endpackage

// File: rtl/gate_tester.sv
// Drives all four input vectors into an external two-input gate, waits for it
// to settle, samples its output and reports which vectors disagreed with TRUTH.
module gate_tester
   import gate_tester_pkg::*;
#(
   parameter logic [3:0]  TRUTH  = TT_AND,
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       y,
   output logic       in1,
   output logic       in2,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_vec
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t     state;
   logic [1:0] vec;
   logic [3:0] settleCnt;
   logic       mismatch;
   logic [3:0] failNext;

   // The vector register doubles as the table index, so in1/in2 stay registered
   assign in1 = vec[1];
   assign in2 = vec[0];

   // Case inequality makes an X or Z from the gate count as a mismatch
   always_comb begin
      mismatch = (y !== TRUTH[vec]);
      failNext = fail_vec | (4'(mismatch) << vec);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         vec       <= 2'd0;
         settleCnt <= 4'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_vec  <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state     <= S_SETTLE;
                  vec       <= 2'd0;
                  settleCnt <= 4'd0;
                  fail_vec  <= 4'd0;
                  pass      <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            S_SETTLE: begin
               if (settleCnt == SETTLE_LAST) begin
                  state     <= S_SAMPLE;
                  settleCnt <= 4'd0;
               end else begin
                  settleCnt <= settleCnt + 4'd1;
               end
            end
            S_SAMPLE: begin
               fail_vec <= failNext;
               if (vec == 2'd3) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (failNext == 4'd0);
               end else begin
                  // Next vector goes out on the same edge that samples this one
                  vec       <= vec + 2'd1;
                  settleCnt <= 4'd0;
                  state     <= S_SETTLE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: three parameterisations share one clock and reset,
// each facing a behavioural gate whose truth table the bench chooses per run.
module tb_gate_tester;
   import gate_tester_pkg::*;

   typedef struct {
      int         inst;
      int         settle;
      logic [3:0] gate;
      logic [3:0] expFail;
      logic       expPass;
   } vector_t;

   logic        clk;
   logic        rst_n;
   logic [2:0]  start;
   logic [3:0]  gateTab [2];
   wire         yA;
   wire         yB;
   wire         yC;
   wire  [2:0]  in1;
   wire  [2:0]  in2;
   wire  [2:0]  busy;
   wire  [2:0]  done;
   wire  [2:0]  pass;
   wire  [11:0] fvAll;

   int errors;
   int checks;

   vector_t vecTable [5];

   // Gate models: A and B look up a bench-chosen table, C floats permanently
   assign yA = gateTab[0][{in1[0], in2[0]}];
   assign yB = gateTab[1][{in1[1], in2[1]}];
   assign yC = 1'bz;

   gate_tester #(.TRUTH(TT_AND), .SETTLE(2)) dutA (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .y(yA),
      .in1(in1[0]), .in2(in2[0]), .busy(busy[0]), .done(done[0]),
      .pass(pass[0]), .fail_vec(fvAll[3:0])
   );

   gate_tester #(.TRUTH(TT_XOR), .SETTLE(1)) dutB (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .y(yB),
      .in1(in1[1]), .in2(in2[1]), .busy(busy[1]), .done(done[1]),
      .pass(pass[1]), .fail_vec(fvAll[7:4])
   );

   gate_tester #(.TRUTH(4'b1111), .SETTLE(3)) dutC (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .y(yC),
      .in1(in1[2]), .in2(in2[2]), .busy(busy[2]), .done(done[2]),
      .pass(pass[2]), .fail_vec(fvAll[11:8])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] failOf(input int inst);
      return fvAll[inst*4 +: 4];
   endfunction

   task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Reference: a vector fails whenever the gate's answer differs from the table
   function automatic logic [3:0] modelFail(input logic [3:0] truth, input logic [3:0] gate);
      logic [3:0] f;
      f = 4'd0;
      for (int v = 0; v < 4; v++)
         if (truth[v] != gate[v]) f[v] = 1'b1;
      return f;
   endfunction

   // One start pulse, then every cycle's outputs are compared until just after done
   task automatic applyStimulus(input int inst, input int settle, input logic [3:0] gate,
                                input logic [3:0] expFail, input logic expPass, input string tag);
      int doneEdge;
      doneEdge = 4 * (settle + 1);
      if (inst < 2) gateTab[inst] = gate;
      @(negedge clk);
      start[inst] = 1'b1;
      for (int c = 0; c <= doneEdge + 1; c++) begin
         @(negedge clk);
         start[inst] = 1'b0;
         if (c < doneEdge) begin
            checkOutput($sformatf("%s busy@%0d", tag, c), {3'b0, busy[inst]}, 4'd1);
            checkOutput($sformatf("%s done@%0d", tag, c), {3'b0, done[inst]}, 4'd0);
            checkOutput($sformatf("%s vec@%0d", tag, c), {2'b0, in1[inst], in2[inst]},
                        4'(c / (settle + 1)));
         end else begin
            checkOutput($sformatf("%s done@%0d", tag, c), {3'b0, done[inst]},
                        (c == doneEdge) ? 4'd1 : 4'd0);
            checkOutput($sformatf("%s busy@%0d", tag, c), {3'b0, busy[inst]}, 4'd0);
            checkOutput($sformatf("%s vec@%0d", tag, c), {2'b0, in1[inst], in2[inst]}, 4'd3);
            checkOutput($sformatf("%s pass@%0d", tag, c), {3'b0, pass[inst]}, {3'b0, expPass});
            checkOutput($sformatf("%s fail_vec@%0d", tag, c), failOf(inst), expFail);
         end
      end
   endtask

   task automatic checkAllReset(input string tag);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("%s busy%0d", tag, i), {3'b0, busy[i]}, 4'd0);
         checkOutput($sformatf("%s done%0d", tag, i), {3'b0, done[i]}, 4'd0);
         checkOutput($sformatf("%s pass%0d", tag, i), {3'b0, pass[i]}, 4'd0);
         checkOutput($sformatf("%s in%0d", tag, i), {2'b0, in1[i], in2[i]}, 4'd0);
         checkOutput($sformatf("%s fail_vec%0d", tag, i), failOf(i), 4'd0);
      end
   endtask

   initial begin
      int doneCount;
      int inst;
      logic [3:0] gate;
      logic [3:0] truth;
      logic [3:0] expFail;

      errors     = 0;
      checks     = 0;
      start      = 3'b000;
      gateTab[0] = TT_AND;
      gateTab[1] = TT_XOR;

      vecTable[0] = '{inst: 0, settle: 2, gate: TT_AND,  expFail: 4'b0000, expPass: 1'b1};
      vecTable[1] = '{inst: 0, settle: 2, gate: TT_OR,   expFail: 4'b0110, expPass: 1'b0};
      vecTable[2] = '{inst: 0, settle: 2, gate: TT_NAND, expFail: 4'b1111, expPass: 1'b0};
      vecTable[3] = '{inst: 1, settle: 1, gate: TT_XOR,  expFail: 4'b0000, expPass: 1'b1};
      vecTable[4] = '{inst: 2, settle: 3, gate: 4'b0000, expFail: 4'b1111, expPass: 1'b0};

      rst_n = 1'b0;
      #12;
      checkAllReset("por");
      @(negedge clk);
      rst_n = 1'b1;

      for (int t = 0; t < 5; t++)
         applyStimulus(vecTable[t].inst, vecTable[t].settle, vecTable[t].gate,
                       vecTable[t].expFail, vecTable[t].expPass, $sformatf("vec%0d", t));

      // Randomised gates against the reference model
      for (int r = 0; r < 8; r++) begin
         inst    = int'($urandom_range(0, 1));
         gate    = 4'($urandom_range(0, 15));
         truth   = (inst == 0) ? TT_AND : TT_XOR;
         expFail = modelFail(truth, gate);
         applyStimulus(inst, (inst == 0) ? 2 : 1, gate, expFail, expFail == 4'd0,
                       $sformatf("rnd%0d", r));
      end

      // start held high: one run, a second only once IDLE is re-entered
      gateTab[0] = TT_AND;
      doneCount  = 0;
      @(negedge clk);
      start[0] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done[0]) doneCount++;
         if (c == 12) checkOutput("hold done@12", {3'b0, done[0]}, 4'd1);
         if (c == 13) checkOutput("hold busy@13", {3'b0, busy[0]}, 4'd0);
         if (c == 14) checkOutput("hold busy@14", {3'b0, busy[0]}, 4'd1);
      end
      start[0] = 1'b0;
      checkOutput("hold done count", 4'(doneCount), 4'd1);
      for (int k = 0; k < 40 && !done[0]; k++) @(negedge clk);
      checkOutput("hold second run done", {3'b0, done[0]}, 4'd1);
      @(negedge clk);

      // Reset mid-run aborts without a done pulse
      @(negedge clk);
      start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 checkAllReset("abort");
      doneCount = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (done[0]) doneCount++;
      end
      checkOutput("abort done count", 4'(doneCount), 4'd0);
      checkOutput("abort idle busy", {3'b0, busy[0]}, 4'd0);
      applyStimulus(0, 2, TT_AND, 4'b0000, 1'b1, "after_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
